// File: rtl/issue_queue_rs.sv
// Reservation station for one execution unit: a collapsing age-ordered queue that captures
// missing operands from result broadcasts and issues the oldest fully-ready entry.
module issue_queue_rs #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int NFWD  = 3,
    parameter int RDW   = 5,
    parameter int OPW   = 6,
    localparam int TAGW = $clog2(NFWD + 1),
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [TAGW-1:0]      in_tag1_i,
    input  logic [TAGW-1:0]      in_tag2_i,
    input  logic [XLEN-1:0]      in_data1_i,
    input  logic [XLEN-1:0]      in_data2_i,
    input  logic [RDW-1:0]       in_rd_i,
    input  logic [OPW-1:0]       in_op_i,
    input  logic [NFWD-1:0]      fwd_valid_i,
    input  logic [NFWD*XLEN-1:0] fwd_data_i,
    output logic                 iss_valid_o,
    input  logic                 iss_ready_i,
    output logic [XLEN-1:0]      iss_op1_o,
    output logic [XLEN-1:0]      iss_op2_o,
    output logic [RDW-1:0]       iss_rd_o,
    output logic [OPW-1:0]       iss_op_o,
    output logic [CNTW-1:0]      count_o
);

    localparam int IDXW = $clog2(DEPTH);

    typedef struct packed {
        logic            valid;
        logic [TAGW-1:0] tag1;
        logic [TAGW-1:0] tag2;
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] data2;
        logic [RDW-1:0]  rd;
        logic [OPW-1:0]  op;
    } slot_t;

    slot_t           slot_q [DEPTH];
    slot_t           slot_d [DEPTH];
    slot_t           slot_w [DEPTH];
    slot_t           slot_sh [DEPTH];
    slot_t           slot_in;
    logic [CNTW-1:0] count_q, count_d, cnt_after;
    logic [IDXW-1:0] sel_idx;
    logic            sel_found, do_issue, do_dispatch;

    // A tag beyond NFWD matches no channel, so such an operand simply never wakes.
    function automatic slot_t wake(input slot_t s, input logic [NFWD-1:0] fv,
                                   input logic [NFWD*XLEN-1:0] fd);
        slot_t r;
        r = s;
        for (int k = 0; k < NFWD; k++) begin
            if (fv[k] && s.tag1 == TAGW'(k + 1)) begin
                r.tag1  = '0;
                r.data1 = fd[k*XLEN +: XLEN];
            end
            if (fv[k] && s.tag2 == TAGW'(k + 1)) begin
                r.tag2  = '0;
                r.data2 = fd[k*XLEN +: XLEN];
            end
        end
        return r;
    endfunction

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found && slot_q[i].valid && slot_q[i].tag1 == '0 && slot_q[i].tag2 == '0) begin
                sel_found = 1'b1;
                sel_idx   = IDXW'(i);
            end
        end
    end

    assign in_ready_o  = (count_q < CNTW'(DEPTH));
    assign iss_valid_o = sel_found && !flush_i;
    assign do_issue    = iss_valid_o && iss_ready_i;
    assign do_dispatch = in_valid_i && in_ready_o && !flush_i;
    assign iss_op1_o   = iss_valid_o ? slot_q[sel_idx].data1 : '0;
    assign iss_op2_o   = iss_valid_o ? slot_q[sel_idx].data2 : '0;
    assign iss_rd_o    = iss_valid_o ? slot_q[sel_idx].rd    : '0;
    assign iss_op_o    = iss_valid_o ? slot_q[sel_idx].op    : '0;
    assign count_o     = count_q;
    assign cnt_after   = count_q - CNTW'(do_issue);

    always_comb begin
        slot_in = wake('{valid: 1'b1, tag1: in_tag1_i, tag2: in_tag2_i, data1: in_data1_i,
                         data2: in_data2_i, rd: in_rd_i, op: in_op_i}, fwd_valid_i, fwd_data_i);
        for (int i = 0; i < DEPTH; i++) begin
            slot_w[i] = wake(slot_q[i], fwd_valid_i, fwd_data_i);
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            slot_sh[i] = slot_w[i + 1];
        end
        slot_sh[DEPTH-1] = '0;
        // Slots at or above the issued one collapse down by one; dispatch lands after compaction.
        for (int i = 0; i < DEPTH; i++) begin
            if (do_issue && i >= int'(sel_idx)) slot_d[i] = slot_sh[i];
            else                                slot_d[i] = slot_w[i];
            if (do_dispatch && CNTW'(i) == cnt_after) slot_d[i] = slot_in;
            if (flush_i) slot_d[i] = '0;
        end
        count_d = flush_i ? '0 : cnt_after + CNTW'(do_dispatch);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            count_q <= '0;
        end else begin
            slot_q  <= slot_d;
            count_q <= count_d;
        end
    end

endmodule
